// File: rtl/queue_reduce_unit_if.sv
// Load and result stream bundle for queue_reduce_unit.
// slave = engine side, master = producer/consumer side.
interface queue_reduce_unit_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic [1:0]       op;
  logic [1:0]       key_mode;
  logic [7:0]       key_arg;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic             out_last;
  logic             out_empty;
  logic [1:0]       status;

  modport master (
    output in_valid, in_data, in_last, op, key_mode, key_arg, out_ready,
    input  in_ready, out_valid, out_data, out_last, out_empty, status
  );

  modport slave (
    input  in_valid, in_data, in_last, op, key_mode, key_arg, out_ready,
    output in_ready, out_valid, out_data, out_last, out_empty, status
  );
endinterface

// File: rtl/queue_reduce_unit.sv
// Queue min/max/unique/unique_index reduction engine with run-time key function.
// Optional QUEUE_REDUCE_UNIQUE_EN builds the UNIQUE/UNIQUE_INDEX dedup path.
module queue_reduce_unit #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter bit SIGNED = 1'b1
) (
  input logic clk,
  input logic rst_n,
  queue_reduce_unit_if.slave bus
);
  localparam int IW = $clog2(DEPTH);
  localparam int CW = IW + 1;

  typedef enum logic [2:0] {IDLE, LOAD, REDUCE, DEDUP, EMIT} state_t;

  state_t           state_r;
  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [CW-1:0]    count_r, scan_r, cmp_r, emit_r;
  logic [IW-1:0]    best_r;
  logic [1:0]       op_r, mode_r;
  logic [7:0]       arg_r;
  logic             ovf_r;
  logic             in_ready_r, out_valid_r, out_last_r, out_empty_r;
  logic [WIDTH-1:0] out_data_r;
  logic [1:0]       status_r;
`ifdef QUEUE_REDUCE_UNIQUE_EN
  logic [IW-1:0]    keep_r [DEPTH];
  logic [CW-1:0]    keep_cnt_r;
  logic [IW-1:0]    beat_idx_s;
`endif

  logic             accept_s, empty_beat_s, load_done_s, unsup_s, better_s;
  logic [1:0]       cur_op_s;
  logic [WIDTH:0]   ka_s, kb_s;
  logic [CW-1:0]    beat_sel_s, res_cnt_s;
  logic [WIDTH-1:0] beat_data_s;
  logic             beat_last_s;

  // Keys carry one extra bit so the addend form can never wrap.
  function automatic logic [WIDTH:0] key_of(input logic [WIDTH-1:0] x,
                                            input logic [1:0] m,
                                            input logic [7:0] a);
    logic [WIDTH:0] xe, ae, mask;
    int w;
    xe = SIGNED ? {x[WIDTH-1], x} : {1'b0, x};
    ae = {{(WIDTH-7){a[7]}}, a};
    w  = (int'(a) > WIDTH) ? WIDTH : int'(a);
    for (int k = 0; k <= WIDTH; k++) mask[k] = (k < w);
    case (m)
      2'd1:    key_of = xe + ae;
      2'd2:    key_of = {1'b0, x} & mask;
      default: key_of = xe;
    endcase
  endfunction

  function automatic logic key_lt(input logic [WIDTH:0] a, input logic [WIDTH:0] b);
    if (SIGNED) key_lt = $signed(a) < $signed(b);
    else        key_lt = a < b;
  endfunction

  // Handshake decode, key evaluation and next result beat selection
  always_comb begin
    accept_s     = bus.in_valid && in_ready_r;
    cur_op_s     = (state_r == IDLE) ? bus.op : op_r;
    empty_beat_s = accept_s && (state_r == IDLE) && bus.in_last &&
                   (bus.key_mode == 2'd3) && (bus.key_arg == 8'hFF);
    load_done_s  = accept_s && (bus.in_last || (count_r == CW'(DEPTH - 1)));
`ifdef QUEUE_REDUCE_UNIQUE_EN
    unsup_s      = 1'b0;
`else
    unsup_s      = cur_op_s[1];
`endif
    ka_s     = key_of(mem_r[scan_r[IW-1:0]], mode_r, arg_r);
    kb_s     = key_of(mem_r[(state_r == DEDUP) ? cmp_r[IW-1:0] : best_r], mode_r, arg_r);
    better_s = op_r[0] ? key_lt(kb_s, ka_s) : key_lt(ka_s, kb_s);
    beat_sel_s = (state_r == EMIT) ? (emit_r + CW'(1)) : {CW{1'b0}};
`ifdef QUEUE_REDUCE_UNIQUE_EN
    beat_idx_s = keep_r[beat_sel_s[IW-1:0]];
    res_cnt_s  = op_r[1] ? keep_cnt_r : CW'(1);
    if (op_r[1]) beat_data_s = op_r[0] ? WIDTH'(beat_idx_s) : mem_r[beat_idx_s];
    else         beat_data_s = mem_r[best_r];
`else
    res_cnt_s   = CW'(1);
    beat_data_s = mem_r[best_r];
`endif
    beat_last_s = ((beat_sel_s + CW'(1)) == res_cnt_s);
  end

  // Queue storage; the empty-queue marker beat carries no element
  always_ff @(posedge clk) begin
    if (accept_s && !empty_beat_s) mem_r[count_r[IW-1:0]] <= bus.in_data;
    else                           mem_r[count_r[IW-1:0]] <= mem_r[count_r[IW-1:0]];
  end

  // Control FSM, scan datapath and registered result beats
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      count_r     <= '0;
      scan_r      <= '0;
      cmp_r       <= '0;
      emit_r      <= '0;
      best_r      <= '0;
      op_r        <= 2'd0;
      mode_r      <= 2'd0;
      arg_r       <= 8'd0;
      ovf_r       <= 1'b0;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_data_r  <= '0;
      out_last_r  <= 1'b0;
      out_empty_r <= 1'b0;
      status_r    <= 2'b00;
`ifdef QUEUE_REDUCE_UNIQUE_EN
      keep_cnt_r  <= '0;
      for (int k = 0; k < DEPTH; k++) keep_r[k] <= '0;
`endif
    end else begin
      case (state_r)
        IDLE, LOAD: begin
          if (accept_s) begin
            state_r <= LOAD;
            if (!empty_beat_s) count_r <= count_r + CW'(1);
            if (state_r == IDLE) begin
              op_r   <= bus.op;
              mode_r <= bus.key_mode;
              arg_r  <= bus.key_arg;
            end
            if (load_done_s) begin
              in_ready_r <= 1'b0;
              ovf_r      <= !bus.in_last;
              scan_r     <= '0;
              cmp_r      <= '0;
              best_r     <= '0;
              emit_r     <= '0;
              if (empty_beat_s || unsup_s) begin
                // Nothing to compute: a single empty beat carries the status.
                state_r     <= EMIT;
                out_valid_r <= 1'b1;
                out_data_r  <= '0;
                out_last_r  <= 1'b1;
                out_empty_r <= 1'b1;
                status_r    <= {unsup_s, !bus.in_last};
              end else if (!cur_op_s[1]) begin
                state_r <= REDUCE;
              end else begin
                state_r <= DEDUP;
                scan_r  <= CW'(1);
`ifdef QUEUE_REDUCE_UNIQUE_EN
                keep_r[0]  <= '0;
                keep_cnt_r <= CW'(1);
`endif
              end
            end
          end
        end
        REDUCE: begin
          if (scan_r == count_r) begin
            state_r     <= EMIT;
            out_valid_r <= 1'b1;
            out_data_r  <= beat_data_s;
            out_last_r  <= beat_last_s;
            out_empty_r <= 1'b0;
            status_r    <= beat_last_s ? {1'b0, ovf_r} : 2'b00;
          end else begin
            if (better_s) best_r <= scan_r[IW-1:0];
            scan_r <= scan_r + CW'(1);
          end
        end
        DEDUP: begin
`ifdef QUEUE_REDUCE_UNIQUE_EN
          if (scan_r >= count_r) begin
            state_r     <= EMIT;
            out_valid_r <= 1'b1;
            out_data_r  <= beat_data_s;
            out_last_r  <= beat_last_s;
            out_empty_r <= 1'b0;
            status_r    <= beat_last_s ? {1'b0, ovf_r} : 2'b00;
          end else if (ka_s == kb_s) begin
            scan_r <= scan_r + CW'(1);
            cmp_r  <= '0;
          end else if ((cmp_r + CW'(1)) == scan_r) begin
            keep_r[keep_cnt_r[IW-1:0]] <= scan_r[IW-1:0];
            keep_cnt_r <= keep_cnt_r + CW'(1);
            scan_r     <= scan_r + CW'(1);
            cmp_r      <= '0;
          end else begin
            cmp_r <= cmp_r + CW'(1);
          end
`else
          state_r <= IDLE;
`endif
        end
        EMIT: begin
          if (bus.out_ready && out_last_r) begin
            state_r     <= IDLE;
            count_r     <= '0;
            ovf_r       <= 1'b0;
            in_ready_r  <= 1'b1;
            out_valid_r <= 1'b0;
            out_data_r  <= '0;
            out_last_r  <= 1'b0;
            out_empty_r <= 1'b0;
            status_r    <= 2'b00;
          end else if (bus.out_ready) begin
            emit_r     <= beat_sel_s;
            out_data_r <= beat_data_s;
            out_last_r <= beat_last_s;
            status_r   <= beat_last_s ? {1'b0, ovf_r} : 2'b00;
          end else begin
            out_data_r <= out_data_r;
          end
        end
        default: state_r <= IDLE;
      endcase
    end
  end

  assign bus.in_ready  = in_ready_r;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_last  = out_last_r;
  assign bus.out_empty = out_empty_r;
  assign bus.status    = status_r;
endmodule

// File: tb/tb_queue_reduce_unit.sv
// Directed vector bench for queue_reduce_unit (signed and unsigned instances).
module tb_queue_reduce_unit;
  localparam int W = 32;
  localparam int D = 16;
`ifdef QUEUE_REDUCE_UNIQUE_EN
  localparam bit UEN = 1'b1;
`else
  localparam bit UEN = 1'b0;
`endif

  typedef struct {
    logic [1:0] op;
    logic [1:0] mode;
    logic [7:0] arg;
    int         n;
    int         d [8];
    int         en;
    int         e [8];
    logic [1:0] st;
    logic       emp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   tests = 0;
  int   fails = 0;
  vec_t vt [11];

  queue_reduce_unit_if #(.WIDTH(W)) ifs ();
  queue_reduce_unit_if #(.WIDTH(W)) ifu ();

  assign ifu.in_valid  = ifs.in_valid;
  assign ifu.in_data   = ifs.in_data;
  assign ifu.in_last   = ifs.in_last;
  assign ifu.op        = ifs.op;
  assign ifu.key_mode  = ifs.key_mode;
  assign ifu.key_arg   = ifs.key_arg;
  assign ifu.out_ready = ifs.out_ready;

  queue_reduce_unit #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b1)) dut_s (.clk(clk), .rst_n(rst_n), .bus(ifs.slave));
  queue_reduce_unit #(.WIDTH(W), .DEPTH(D), .SIGNED(1'b0)) dut_u (.clk(clk), .rst_n(rst_n), .bus(ifu.slave));

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic load(input logic [1:0] op, input logic [1:0] mode, input logic [7:0] arg,
                      input int n, input int d [8]);
    for (int i = 0; i < n; i++) begin
      ifs.in_valid = 1'b1; ifs.in_data = W'(d[i]); ifs.in_last = (i == n - 1);
      ifs.op = op; ifs.key_mode = mode; ifs.key_arg = arg;
      @(posedge clk); #1;
    end
    ifs.in_valid = 1'b0; ifs.in_last = 1'b0;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!ifs.out_valid && cyc < 400) begin
      @(posedge clk); #1; cyc++;
    end
    if (!ifs.out_valid) chk("out_valid timeout", {31'd0, ifs.out_valid}, 32'd1);
  endtask

  task automatic run_vec(input int idx, input vec_t v);
    int cyc, b;
    int dd [8];
    ifs.out_ready = 1'b1;
    if (v.n == 0) begin
      dd = '{0, 0, 0, 0, 0, 0, 0, 0};
      load(v.op, 2'd3, 8'hFF, 1, dd);
    end else begin
      load(v.op, v.mode, v.arg, v.n, v.d);
    end
    wait_out(cyc);
    if (v.op < 2'd2 && v.n > 0) chk($sformatf("v%0d latency", idx), W'(cyc), W'(v.n + 1));
    b = 0;
    while (ifs.out_valid && b < 9) begin
      chk($sformatf("v%0d beat%0d data", idx, b), ifs.out_data, W'(v.e[b < 8 ? b : 7]));
      chk($sformatf("v%0d beat%0d last", idx, b), {31'd0, ifs.out_last}, {31'd0, (b == v.en - 1)});
      chk($sformatf("v%0d beat%0d empty", idx, b), {31'd0, ifs.out_empty}, {31'd0, v.emp});
      b++;
      if (ifs.out_last) begin
        chk($sformatf("v%0d status", idx), {30'd0, ifs.status}, {30'd0, v.st});
        break;
      end
      @(posedge clk); #1;
    end
    chk($sformatf("v%0d beat count", idx), W'(b), W'(v.en));
    @(posedge clk); #1;
    chk($sformatf("v%0d idle in_ready", idx), {31'd0, ifs.in_ready}, 32'd1);
  endtask

  initial begin
    int cyc, acc;
    logic ir16;
    int dd [8];
    int be [8];
    int ben;

    vt[0]  = '{2'd2, 2'd2, 8'd1, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 2, '{2, 1, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[1]  = '{2'd3, 2'd2, 8'd2, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 4, '{0, 2, 3, 4, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[2]  = '{2'd0, 2'd1, 8'd1, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 1, '{1, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[3]  = '{2'd1, 2'd2, 8'd2, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 1, '{3, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[4]  = '{2'd0, 2'd2, 8'd2, 3, '{5, 1, 9, 0, 0, 0, 0, 0}, 1, '{5, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[5]  = '{2'd0, 2'd0, 8'd0, 3, '{3, -5, 2, 0, 0, 0, 0, 0}, 1, '{-5, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[6]  = '{2'd1, 2'd1, 8'hFE, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 1, '{4, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[7]  = '{2'd0, 2'd3, 8'hFF, 0, '{0, 0, 0, 0, 0, 0, 0, 0}, 1, '{0, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b1};
    vt[8]  = '{2'd2, 2'd0, 8'd0, 5, '{2, 2, 4, 1, 3, 0, 0, 0}, 4, '{2, 4, 1, 3, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[9]  = '{2'd1, 2'd0, 8'd1, 1, '{9, 0, 0, 0, 0, 0, 0, 0}, 1, '{9, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    vt[10] = '{2'd2, 2'd0, 8'd0, 1, '{6, 0, 0, 0, 0, 0, 0, 0}, 1, '{6, 0, 0, 0, 0, 0, 0, 0}, 2'b00, 1'b0};
    for (int i = 0; i < 11; i++) begin
      if (!UEN && vt[i].op[1] && vt[i].n > 0) begin
        vt[i].en = 1; vt[i].e[0] = 0; vt[i].st = 2'b10; vt[i].emp = 1'b1;
      end
    end

    ifs.in_valid = 1'b0; ifs.in_data = '0; ifs.in_last = 1'b0; ifs.op = 2'd0;
    ifs.key_mode = 2'd0; ifs.key_arg = 8'd0; ifs.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst in_ready", {31'd0, ifs.in_ready}, 32'd1);
    chk("rst out_valid", {31'd0, ifs.out_valid}, 32'd0);
    chk("rst out_data", ifs.out_data, 32'd0);
    chk("rst flags", {29'd0, ifs.out_last, ifs.out_empty, ifs.status[0]}, 32'd0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 11; i++) run_vec(i, vt[i]);

    // Overflow: DEPTH+2 beats without in_last, MAX sees only the first DEPTH values.
    acc = 0; ir16 = 1'b1;
    for (int i = 0; i < D + 2; i++) begin
      ifs.in_valid = 1'b1; ifs.in_data = W'(i + 1); ifs.in_last = 1'b0;
      ifs.op = 2'd1; ifs.key_mode = 2'd0; ifs.key_arg = 8'd0;
      if (i == D) ir16 = ifs.in_ready;
      if (ifs.in_ready) acc++;
      @(posedge clk); #1;
    end
    ifs.in_valid = 1'b0;
    chk("ovf accepted", W'(acc), W'(D));
    chk("ovf in_ready low", {31'd0, ir16}, 32'd0);
    wait_out(cyc);
    chk("ovf data", ifs.out_data, W'(D));
    chk("ovf last", {31'd0, ifs.out_last}, 32'd1);
    chk("ovf status", {30'd0, ifs.status}, 32'd1);
    @(posedge clk); #1;

    // Backpressure: each beat held 5 cycles with out_ready low.
    dd = '{7, 7, 8, 9, 8, 0, 0, 0};
    if (UEN) begin ben = 3; be = '{7, 8, 9, 0, 0, 0, 0, 0}; end
    else     begin ben = 1; be = '{0, 0, 0, 0, 0, 0, 0, 0}; end
    ifs.out_ready = 1'b0;
    load(2'd2, 2'd0, 8'd0, 5, dd);
    wait_out(cyc);
    for (int b = 0; b < ben; b++) begin
      for (int k = 0; k < 5; k++) begin
        chk($sformatf("hold b%0d c%0d", b, k), {ifs.out_valid, ifs.out_last, ifs.out_data[29:0]},
            {1'b1, (b == ben - 1), 30'(be[b])});
        @(posedge clk); #1;
      end
      ifs.out_ready = 1'b1;
      @(posedge clk); #1;
      ifs.out_ready = 1'b0;
    end
    chk("hold drained", {31'd0, ifs.out_valid}, 32'd0);

    // Reset during compute aborts without emitting anything.
    dd = '{1, 2, 3, 4, 5, 6, 7, 8};
    load(2'd2, 2'd0, 8'd0, 8, dd);
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("mid rst out_valid", {31'd0, ifs.out_valid}, 32'd0);
    chk("mid rst in_ready", {31'd0, ifs.in_ready}, 32'd1);
    chk("mid rst out", {ifs.out_data[28:0], ifs.out_last, ifs.out_empty, ifs.status[1]}, 32'd0);
    @(negedge clk) rst_n = 1'b1;
    ifs.out_ready = 1'b1;
    acc = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (ifs.out_valid) acc++;
    end
    chk("no partial result", W'(acc), 32'd0);

    // Signedness: MAX {-3,7}.
    dd = '{-3, 7, 0, 0, 0, 0, 0, 0};
    load(2'd1, 2'd0, 8'd0, 2, dd);
    wait_out(cyc);
    chk("max signed", ifs.out_data, 32'd7);
    chk("max unsigned valid", {31'd0, ifu.out_valid}, 32'd1);
    chk("max unsigned", ifu.out_data, 32'hFFFFFFFD);
    @(posedge clk); #1;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/queue_reduce_unit.md
# queue_reduce_unit

Streaming hardware engine for the SystemVerilog queue reduction methods `min/max/unique/unique_index ... with (key)`. A queue of up to DEPTH elements is loaded over a valid/ready stream, reduced with a run-time key function, and the result elements or indices are streamed out. The engine sits behind the UVM-feature test harness as the synthesizable reference model for queue-method results, generalising the fixed-`int` behaviour to parametrised width, depth and key modes.

## Interface
- WIDTH, 32: element width in bits.
- DEPTH, 16: maximum queue length (≥2); IW = $clog2(DEPTH).
- SIGNED, 1: 1 = elements and keys compare as signed, 0 = unsigned.
- clk  in  1  clock; all logic on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid / in_ready  in / out  1  load handshake.
- in_data  in  WIDTH  element.
- in_last  in  1  final element of the queue.
- op  in  2  0 MIN, 1 MAX, 2 UNIQUE, 3 UNIQUE_INDEX; sampled on the first accepted beat.
- key_mode  in  2  0 key=x, 1 key=x+key_arg (sign-extended), 2 key=x mod 2^key_arg (low bits, unsigned); 3 reserved, treated as 0. Sampled with op.
- key_arg  in  8  addend or mask width (mask width clamped to WIDTH).
- out_valid / out_ready  out / in  1  result handshake.
- out_data  out  WIDTH  result element (UNIQUE_INDEX: zero-extended index).
- out_last  out  1  final result beat.
- out_empty  out  1  result set is empty; data is 0.
- status  out  2  bit0 overflow (queue truncated), bit1 unsupported op; valid with out_valid on the last beat.

## Operation
- States: IDLE, LOAD, REDUCE, DEDUP, EMIT.
- IDLE/LOAD: in_ready=1 while count<DEPTH. Each accepted beat is stored at index count, and count increments. An accepted in_last moves the FSM to the compute state. The DEPTH-th beat without in_last also moves it there and sets overflow, so in_ready drops.
- Empty queue: in_last carries no element only if in_data is ignored, so the empty queue is instead signalled by in_valid with in_last on a beat that has key_mode=3 and key_arg=0xFF. EMIT then produces one beat with out_empty=1.
- Keys are computed in WIDTH+1 bits, so x+key_arg never wraps.
- REDUCE (MIN/MAX): one element per cycle. The running best is replaced only on a strictly better key, so ties keep the first occurrence. The result is the element, not the key. One output beat.
- DEDUP (UNIQUE/UNIQUE_INDEX): for each i, compare key(i) with key(j) for j<i, one compare per cycle. On the first match, i is dropped and the scan advances immediately. If no match is found, i is appended to a keep list (IW-bit indices). The worst case is N(N-1)/2 cycles. Element 0 is always kept.
- EMIT: one beat per result in original queue order. out_data/out_last are held stable while out_valid && !out_ready. After the final handshake the FSM returns to IDLE and clears status.

## Timing
- Reset: FSM=IDLE; count, pointers and status are 0; in_ready=1; out_valid=0; out_data=0; out_last=0; out_empty=0.
- Load: 1 element/cycle.
- MIN/MAX: out_valid rises N+1 cycles after in_last is accepted.
- UNIQUE: out_valid rises 1 cycle after the last DEDUP compare.
- in_ready=0 in REDUCE, DEDUP and EMIT. The next queue load can start the cycle after the last output handshake.
- rst_n asserted mid-operation aborts immediately; partial results are never emitted.
- Registered outputs only; no combinational path from in_* to out_*.

## Configuration
- QUEUE_REDUCE_UNIQUE_EN defined: UNIQUE/UNIQUE_INDEX, the DEDUP state and the keep list are built.
- Not defined: those ops skip compute and emit one beat with out_empty=1 and status[1]=1. MIN/MAX are unaffected.

## Test plan
- Load {2,2,4,1,3}, UNIQUE, key_mode 2, key_arg 1 → beats 2, 1 (out_last on 1), status 0.
- Same queue, UNIQUE_INDEX, key_mode 2, key_arg 2 (keys 2,2,0,1,3) → 0, 2, 3, 4.
- Same queue, MIN, key_mode 1, key_arg 1 → single beat 1. MAX, key_mode 2, key_arg 2 → 3. MIN on {5,5,-1 ... ties} returns the first occurrence index element.
- DEPTH+2 beats, no in_last → only DEPTH accepted, in_ready low after the DEPTH-th beat, status[0]=1 on the last beat.
- UNIQUE result of 3 beats with out_ready held 0 for 5 cycles per beat → data stable, order preserved, no beat lost or duplicated.
- rst_n pulsed during DEDUP → outputs at reset values. A following MAX on {-3,7} with SIGNED=1 returns 7, and with SIGNED=0 returns -3 (0xFFFFFFFD).
